// File: rtl/if_fetch_if.sv
// if_fetch_if: instruction-memory request/response bus.
// master = fetch stage, slave = memory.
interface if_fetch_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
);
  logic                  imem_req_o;
  logic [ADDR_WIDTH-1:0] imem_addr_o;
  logic                  imem_gnt_i;
  logic                  imem_rvalid_i;
  logic [DATA_WIDTH-1:0] imem_rdata_i;

  modport master (
    output imem_req_o,
    output imem_addr_o,
    input  imem_gnt_i,
    input  imem_rvalid_i,
    input  imem_rdata_i
  );

  modport slave (
    input  imem_req_o,
    input  imem_addr_o,
    output imem_gnt_i,
    output imem_rvalid_i,
    output imem_rdata_i
  );
endinterface

// File: rtl/if_fetch.sv
// if_fetch: single-outstanding fetch with a small {instr, pc} FIFO.
// Option macro: FETCH_MISALIGN_TRAP_EN (misaligned PC -> error entry).
module if_fetch #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int FifoDepth  = 2
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic [ADDR_WIDTH-1:0] pc_i,
  input  logic                  flush_i,
  output logic                  pc_en_o,
  if_fetch_if.master            imem,
  output logic                  instr_valid_o,
  input  logic                  instr_ready_i,
  output logic [DATA_WIDTH-1:0] instr_o,
  output logic [ADDR_WIDTH-1:0] instr_pc_o,
  output logic                  instr_err_o
);
  localparam int PW = $clog2(FifoDepth);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] DEPTH = CW'(FifoDepth);

  typedef enum logic [1:0] {IDLE, REQ, WAIT} state_e;

  state_e                state_q, state_d;
  logic                  drop_q, drop_d;
  logic                  trap_q, trap_d;
  logic [ADDR_WIDTH-1:0] pend_q, pend_d;
  logic [CW-1:0]         cnt_q;
  logic [PW-1:0]         wptr_q, rptr_q;
  logic [DATA_WIDTH-1:0] data_q [FifoDepth];
  logic [ADDR_WIDTH-1:0] pcs_q  [FifoDepth];

  logic                  req, push, pop, misalign;
  logic [DATA_WIDTH-1:0] push_data;
  logic [ADDR_WIDTH-1:0] push_pc;
  logic [ADDR_WIDTH-1:0] addr;

`ifdef FETCH_MISALIGN_TRAP_EN
  logic                  err_q [FifoDepth];
  logic                  push_err;
  assign misalign    = pc_i[1:0] != 2'b00;
  assign instr_err_o = instr_valid_o & err_q[rptr_q];
`else
  logic                  unused_pc_lsb;
  assign unused_pc_lsb = ^pc_i[1:0];
  assign misalign      = 1'b0;
  assign instr_err_o   = 1'b0;
`endif

  assign addr             = {pc_i[ADDR_WIDTH-1:2], 2'b00};
  assign imem.imem_req_o  = req;
  assign imem.imem_addr_o = req ? addr : '0;
  assign instr_valid_o    = cnt_q != '0;
  assign pop              = instr_valid_o & instr_ready_i;
  assign instr_o          = data_q[rptr_q];
  assign instr_pc_o       = pcs_q[rptr_q];

  // Fetch control: request issue, response capture, redirect handling.
  always_comb begin
    state_d   = state_q;
    drop_d    = drop_q;
    trap_d    = trap_q;
    pend_d    = pend_q;
    req       = 1'b0;
    pc_en_o   = 1'b0;
    push      = 1'b0;
    push_data = '0;
    push_pc   = pend_q;
`ifdef FETCH_MISALIGN_TRAP_EN
    push_err  = 1'b0;
`endif
    unique case (state_q)
      IDLE: begin
        if (flush_i) begin
          state_d = REQ;
          trap_d  = 1'b0;
        end else if (!trap_q && cnt_q < DEPTH) begin
          state_d = REQ;
        end
      end
      REQ: begin
        if (!flush_i && misalign) begin
          push    = 1'b1;
          push_pc = pc_i;
          state_d = IDLE;
          trap_d  = 1'b1;
`ifdef FETCH_MISALIGN_TRAP_EN
          push_err = 1'b1;
`endif
        end else begin
          req = 1'b1;
          if (imem.imem_gnt_i) begin
            pend_d  = addr;
            state_d = WAIT;
            if (flush_i) drop_d  = 1'b1;
            else         pc_en_o = 1'b1;
          end
        end
      end
      WAIT: begin
        if (imem.imem_rvalid_i) begin
          drop_d = 1'b0;
          if (!drop_q && !flush_i) begin
            push      = 1'b1;
            push_data = imem.imem_rdata_i;
            push_pc   = pend_q;
          end
          if (flush_i ||
              (cnt_q + CW'(push) - CW'(pop)) < DEPTH)
            state_d = REQ;
          else
            state_d = IDLE;
        end else if (flush_i) begin
          drop_d = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Control state registers.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      drop_q  <= 1'b0;
      trap_q  <= 1'b0;
      pend_q  <= '0;
    end else begin
      state_q <= state_d;
      drop_q  <= drop_d;
      trap_q  <= trap_d;
      pend_q  <= pend_d;
    end
  end

  // Instruction FIFO; a redirect empties it in one cycle.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cnt_q  <= '0;
      wptr_q <= '0;
      rptr_q <= '0;
      for (int i = 0; i < FifoDepth; i++) begin
        data_q[i] <= '0;
        pcs_q[i]  <= '0;
`ifdef FETCH_MISALIGN_TRAP_EN
        err_q[i]  <= 1'b0;
`endif
      end
    end else if (flush_i) begin
      cnt_q  <= '0;
      wptr_q <= '0;
      rptr_q <= '0;
    end else begin
      if (push) begin
        data_q[wptr_q] <= push_data;
        pcs_q[wptr_q]  <= push_pc;
`ifdef FETCH_MISALIGN_TRAP_EN
        err_q[wptr_q]  <= push_err;
`endif
        wptr_q <= wptr_q + 1'b1;
      end
      if (pop) rptr_q <= rptr_q + 1'b1;
      cnt_q <= cnt_q + CW'(push) - CW'(pop);
    end
  end
endmodule
